pkt_ingress_checker: RTL and testbench
======================================

// Module: pkt_ingress_checker
// PURPOSE
//  Ingress framing/length checker sitting directly upstream of the pass-through stage.
//  Consumes a raw 139-bit word stream and writes that stage's packet FIFO and per-packet valid FIFO.
//  Every packet written downstream ends in a tail word and gets exactly one valid flag (1=forward, 0=discard).
//  Words that cannot be closed cleanly are never written.
// PARAMETERS
//  MIN_WORDS    4       minimum legal packet length in words (head..tail inclusive, 64B)
//  MAX_WORDS    96      maximum legal packet length in words (1536B)
//  FULL_THRESH  8'd160  downstream pkt FIFO usedw above which a new packet is dropped whole
// PORTS
//  clk             in   1    single clock
//  reset           in   1    synchronous, active-high
//  in_pkt_wrreq    in   1    input word strobe
//  in_pkt          in   139  [138:136] type (101 head, 100 body, 110 tail), [135:132] empty bytes, [127:0] data
//  in_pkt_usedw    out  8    = out_pkt_usedw, combinational; upstream uses it for flow control
//  out_pkt_wrreq   out  1    write strobe to downstream pkt FIFO (256x139)
//  out_pkt         out  139  word to downstream pkt FIFO
//  out_pkt_usedw   in   8    downstream pkt FIFO fill level
//  out_valid_wrreq out  1    write strobe to downstream valid FIFO (64x1)
//  out_valid       out  1    per-packet verdict
//  cnt_good        out  32   packets written with valid=1 (wraps)
//  cnt_bad         out  32   packets written with valid=0 (wraps)
//  cnt_drop        out  32   packets/orphan fragments never written (wraps)
// BEHAVIOUR
//  - Reset: all outputs except in_pkt_usedw 0 (out_pkt 0), state IDLE, word count 0, counters 0.
//    Mid-packet reset abandons the packet; the downstream FIFOs share this reset and are cleared too.
//  - Latency: out_* registered, 1 cycle after the in_pkt_wrreq word. No input backpressure; throughput 1 word/clk.
//  - out_valid_wrreq/out_valid are asserted in the same cycle as the tail's out_pkt_wrreq. Never before the tail.
//  - wcnt counts the words of the current packet, head=1; width $clog2(MAX_WORDS+1).
//  - States: IDLE, PKT, DROP.
//  - IDLE:
//    - head, out_pkt_usedw<=FULL_THRESH: write head, wcnt=1 -> PKT.
//    - head, usedw>FULL_THRESH: no write, cnt_drop++ -> DROP.
//    - body: no write, cnt_drop++ -> DROP.
//    - tail or illegal type: no write, cnt_drop++, stay IDLE.
//  - PKT, body, wcnt+1<MAX_WORDS: write word unchanged, wcnt++.
//  - PKT, tail, wcnt+1<=MAX_WORDS: write word; valid = (wcnt+1>=MIN_WORDS); cnt_good or cnt_bad++ -> IDLE.
//  - PKT, body as the MAX_WORDS-th word: write it with type forced to 110, valid=0, cnt_bad++ -> DROP (oversize).
//  - PKT, head or illegal type (truncation): write that word with type forced to 110 (data kept), valid=0,
//    cnt_bad++. New packet not written, cnt_drop++ -> DROP.
//  - DROP: discard every word. Tail -> IDLE. Head stays DROP (no new head accepted until a tail).
//  - No in_pkt_wrreq: outputs' wrreq deasserted, state/wcnt hold. Idle gaps inside a packet are legal.
//  - One write per cycle max; the synthetic-tail cases reuse the offending word's slot, so no skid buffer exists.
//  - Counters increment in the cycle the verdict/drop is registered; a good/bad and a drop in the same cycle
//    both count.
// STRUCTURE
//  - Package pkt_fmt_pkg: PKT_W=139, TYPE_HEAD=3'b101, TYPE_BODY=3'b100, TYPE_TAIL=3'b110, field ranges, state enum.
//  - One sub-module: pkt_chk_stats (three 32-bit wrap counters with inc strobes). Checker FSM stays in top.
// TESTING
//  - 6-word good pkt (101,100x4,110) -> 6 out writes in order, 1-cycle latency, valid=1 with tail, cnt_good=1.
//  - 3-word pkt (below MIN_WORDS=4) -> 3 writes, valid=0 with tail, cnt_bad=1.
//  - 120-word pkt -> 96 writes, word 96 type 110, valid=0, words 97..120 dropped, cnt_bad=1.
//  - Head at word 5, then an 8-word pkt -> word 5 written as 110 with head data, valid=0.
//    Following body/tail dropped; next head accepted. cnt_bad=1, cnt_drop=1.
//  - Orphan body+tail in IDLE, and lone tail in IDLE -> no writes, cnt_drop=2.
//  - out_pkt_usedw=161 at head -> whole pkt dropped, cnt_drop=1. usedw=160 at head -> pkt accepted.
//  - Reset asserted at word 3 of a pkt -> next cycle all strobes 0, state IDLE, counters 0.
//    Next good pkt passes with valid=1.

Source files
------------

// File: rtl/pkt_fmt_pkg.sv
// Word format, type codes and checker state encoding shared by the ingress checker.
package pkt_fmt_pkg;

    localparam int unsigned PKT_W  = 139;
    localparam int unsigned DATA_W = 128;
    localparam int unsigned CNT_W  = 32;

    localparam logic [2:0] TYPE_HEAD = 3'b101;
    localparam logic [2:0] TYPE_BODY = 3'b100;
    localparam logic [2:0] TYPE_TAIL = 3'b110;

    // Field layout: [138:136] type, [135:132] empty bytes, [131:128] unused, [127:0] data.
    typedef struct packed {
        logic [2:0]        ptype;
        logic [3:0]        empty;
        logic [3:0]        rsvd;
        logic [DATA_W-1:0] data;
    } pkt_word_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PKT  = 2'd1,
        ST_DROP = 2'd2
    } chk_state_e;

    // Turns the offending word into a synthetic tail, keeping its payload.
    function automatic pkt_word_t force_tail(input pkt_word_t w);
        pkt_word_t r;
        r       = w;
        r.ptype = TYPE_TAIL;
        return r;
    endfunction

endpackage

// File: rtl/pkt_chk_stats.sv
// Good/bad/drop packet counters; each wraps at 2^32.
module pkt_chk_stats
    import pkt_fmt_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             inc_good,
    input  logic             inc_bad,
    input  logic             inc_drop,
    output logic [CNT_W-1:0] cnt_good,
    output logic [CNT_W-1:0] cnt_bad,
    output logic [CNT_W-1:0] cnt_drop
);

    logic [CNT_W-1:0] cnt_good_q, cnt_good_d;
    logic [CNT_W-1:0] cnt_bad_q,  cnt_bad_d;
    logic [CNT_W-1:0] cnt_drop_q, cnt_drop_d;

    // Next counter values from the increment strobes.
    always_comb begin
        cnt_good_d = cnt_good_q + CNT_W'(inc_good);
        cnt_bad_d  = cnt_bad_q  + CNT_W'(inc_bad);
        cnt_drop_d = cnt_drop_q + CNT_W'(inc_drop);
    end

    // Counter registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_good_q <= '0;
            cnt_bad_q  <= '0;
            cnt_drop_q <= '0;
        end else begin
            cnt_good_q <= cnt_good_d;
            cnt_bad_q  <= cnt_bad_d;
            cnt_drop_q <= cnt_drop_d;
        end
    end

    assign cnt_good = cnt_good_q;
    assign cnt_bad  = cnt_bad_q;
    assign cnt_drop = cnt_drop_q;

endmodule

// File: rtl/pkt_ingress_checker.sv
// Ingress framing/length checker: forwards well-framed packets, closes broken ones
// with a synthetic tail and drops whatever cannot be closed cleanly.
module pkt_ingress_checker
    import pkt_fmt_pkg::*;
#(
    parameter int unsigned MIN_WORDS   = 4,
    parameter int unsigned MAX_WORDS   = 96,
    parameter logic [7:0]  FULL_THRESH = 8'd160
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_pkt_wrreq,
    input  logic [PKT_W-1:0] in_pkt,
    output logic [7:0]       in_pkt_usedw,
    output logic             out_pkt_wrreq,
    output logic [PKT_W-1:0] out_pkt,
    input  logic [7:0]       out_pkt_usedw,
    output logic             out_valid_wrreq,
    output logic             out_valid,
    output logic [CNT_W-1:0] cnt_good,
    output logic [CNT_W-1:0] cnt_bad,
    output logic [CNT_W-1:0] cnt_drop
);

    localparam int unsigned          WCNT_W = $clog2(MAX_WORDS + 1);
    localparam logic [WCNT_W-1:0]    MIN_C  = WCNT_W'(MIN_WORDS);
    localparam logic [WCNT_W-1:0]    MAX_C  = WCNT_W'(MAX_WORDS);

    chk_state_e        state_q, state_d;
    logic [WCNT_W-1:0] wcnt_q, wcnt_d;
    logic [WCNT_W-1:0] wcnt_inc;
    pkt_word_t         in_w;
    pkt_word_t         out_pkt_q, out_pkt_d;
    logic              out_pkt_wrreq_q, out_pkt_wrreq_d;
    logic              out_valid_wrreq_q, out_valid_wrreq_d;
    logic              out_valid_q, out_valid_d;
    logic              inc_good, inc_bad, inc_drop;

    assign in_w     = pkt_word_t'(in_pkt);
    assign wcnt_inc = wcnt_q + WCNT_W'(1);

    // Framing FSM: next state, word count, registered write/verdict and counter strobes.
    always_comb begin
        state_d           = state_q;
        wcnt_d            = wcnt_q;
        out_pkt_d         = out_pkt_q;
        out_pkt_wrreq_d   = 1'b0;
        out_valid_wrreq_d = 1'b0;
        out_valid_d       = 1'b0;
        inc_good          = 1'b0;
        inc_bad           = 1'b0;
        inc_drop          = 1'b0;

        if (in_pkt_wrreq) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (in_w.ptype == TYPE_HEAD) begin
                        if (out_pkt_usedw <= FULL_THRESH) begin
                            out_pkt_d       = in_w;
                            out_pkt_wrreq_d = 1'b1;
                            wcnt_d          = WCNT_W'(1);
                            state_d         = ST_PKT;
                        end else begin
                            inc_drop = 1'b1;
                            state_d  = ST_DROP;
                        end
                    end else if (in_w.ptype == TYPE_BODY) begin
                        inc_drop = 1'b1;
                        state_d  = ST_DROP;
                    end else begin
                        inc_drop = 1'b1;
                    end
                end
                ST_PKT: begin
                    out_pkt_wrreq_d = 1'b1;
                    if (in_w.ptype == TYPE_BODY && wcnt_inc < MAX_C) begin
                        out_pkt_d = in_w;
                        wcnt_d    = wcnt_inc;
                    end else if (in_w.ptype == TYPE_TAIL) begin
                        out_pkt_d         = in_w;
                        out_valid_wrreq_d = 1'b1;
                        out_valid_d       = (wcnt_inc >= MIN_C);
                        inc_good          = (wcnt_inc >= MIN_C);
                        inc_bad           = (wcnt_inc <  MIN_C);
                        wcnt_d            = '0;
                        state_d           = ST_IDLE;
                    end else begin
                        // Oversize body, premature head or illegal type: close with a synthetic tail.
                        out_pkt_d         = force_tail(in_w);
                        out_valid_wrreq_d = 1'b1;
                        inc_bad           = 1'b1;
                        inc_drop          = (in_w.ptype != TYPE_BODY);
                        wcnt_d            = '0;
                        state_d           = ST_DROP;
                    end
                end
                ST_DROP: begin
                    if (in_w.ptype == TYPE_TAIL) begin
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    wcnt_d  = '0;
                end
            endcase
        end
    end

    // State, word count and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q           <= ST_IDLE;
            wcnt_q            <= '0;
            out_pkt_q         <= '0;
            out_pkt_wrreq_q   <= 1'b0;
            out_valid_wrreq_q <= 1'b0;
            out_valid_q       <= 1'b0;
        end else begin
            state_q           <= state_d;
            wcnt_q            <= wcnt_d;
            out_pkt_q         <= out_pkt_d;
            out_pkt_wrreq_q   <= out_pkt_wrreq_d;
            out_valid_wrreq_q <= out_valid_wrreq_d;
            out_valid_q       <= out_valid_d;
        end
    end

    pkt_chk_stats u_stats (
        .clk      (clk),
        .reset    (reset),
        .inc_good (inc_good),
        .inc_bad  (inc_bad),
        .inc_drop (inc_drop),
        .cnt_good (cnt_good),
        .cnt_bad  (cnt_bad),
        .cnt_drop (cnt_drop)
    );

    assign in_pkt_usedw    = out_pkt_usedw;
    assign out_pkt         = out_pkt_q;
    assign out_pkt_wrreq   = out_pkt_wrreq_q;
    assign out_valid_wrreq = out_valid_wrreq_q;
    assign out_valid       = out_valid_q;

endmodule

// File: tb/tb_pkt_ingress_checker.sv
// Directed vector bench for pkt_ingress_checker.
module tb_pkt_ingress_checker;

    localparam logic [2:0] H = 3'b101;
    localparam logic [2:0] B = 3'b100;
    localparam logic [2:0] T = 3'b110;
    localparam logic [2:0] X = 3'b000;

    logic         clk;
    logic         reset;
    logic         in_pkt_wrreq;
    logic [138:0] in_pkt;
    logic [7:0]   in_pkt_usedw;
    logic         out_pkt_wrreq;
    logic [138:0] out_pkt;
    logic [7:0]   out_pkt_usedw;
    logic         out_valid_wrreq;
    logic         out_valid;
    logic [31:0]  cnt_good;
    logic [31:0]  cnt_bad;
    logic [31:0]  cnt_drop;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        logic        wr;
        logic [2:0]  typ;
        logic [7:0]  tag;
        logic [7:0]  usedw;
        logic        e_wr;
        logic [2:0]  e_typ;
        logic        e_vwr;
        logic        e_val;
        logic [31:0] e_good;
        logic [31:0] e_bad;
        logic [31:0] e_drop;
    } vec_t;

    vec_t vq[$];

    pkt_ingress_checker dut (
        .clk             (clk),
        .reset           (reset),
        .in_pkt_wrreq    (in_pkt_wrreq),
        .in_pkt          (in_pkt),
        .in_pkt_usedw    (in_pkt_usedw),
        .out_pkt_wrreq   (out_pkt_wrreq),
        .out_pkt         (out_pkt),
        .out_pkt_usedw   (out_pkt_usedw),
        .out_valid_wrreq (out_valid_wrreq),
        .out_valid       (out_valid),
        .cnt_good        (cnt_good),
        .cnt_bad         (cnt_bad),
        .cnt_drop        (cnt_drop)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [138:0] word(input logic [2:0] typ, input logic [7:0] tag);
        return {typ, tag[3:0], 4'h0, {16{tag}}};
    endfunction

    function automatic vec_t mk(input logic wr, input logic [2:0] typ, input logic [7:0] tag,
                                input logic [7:0] usedw, input logic e_wr, input logic [2:0] e_typ,
                                input logic e_vwr, input logic e_val,
                                input int g, input int b, input int d);
        vec_t v;
        v.wr = wr; v.typ = typ; v.tag = tag; v.usedw = usedw;
        v.e_wr = e_wr; v.e_typ = e_typ; v.e_vwr = e_vwr; v.e_val = e_val;
        v.e_good = 32'(g); v.e_bad = 32'(b); v.e_drop = 32'(d);
        return v;
    endfunction

    task automatic chk(input string name, input logic [138:0] act, input logic [138:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Drive one input cycle and compare the registered response one clock later.
    task automatic apply(input vec_t v);
        in_pkt_wrreq  = v.wr;
        in_pkt        = word(v.typ, v.tag);
        out_pkt_usedw = v.usedw;
        @(posedge clk);
        #1;
        chk($sformatf("wrreq tag%0h", v.tag), 139'(out_pkt_wrreq), 139'(v.e_wr));
        if (v.e_wr) chk($sformatf("out_pkt tag%0h", v.tag), out_pkt, word(v.e_typ, v.tag));
        chk($sformatf("valid_wrreq tag%0h", v.tag), 139'(out_valid_wrreq), 139'(v.e_vwr));
        if (v.e_vwr) chk($sformatf("valid tag%0h", v.tag), 139'(out_valid), 139'(v.e_val));
        chk($sformatf("cnt_good tag%0h", v.tag), 139'(cnt_good), 139'(v.e_good));
        chk($sformatf("cnt_bad tag%0h", v.tag), 139'(cnt_bad), 139'(v.e_bad));
        chk($sformatf("cnt_drop tag%0h", v.tag), 139'(cnt_drop), 139'(v.e_drop));
    endtask

    initial begin
        // 6-word good packet with an idle gap inside
        vq.push_back(mk(1, H, 8'h11, 8'd0,   1, H, 0, 0, 0, 0, 0));
        vq.push_back(mk(1, B, 8'h12, 8'd0,   1, B, 0, 0, 0, 0, 0));
        vq.push_back(mk(0, B, 8'h00, 8'd0,   0, B, 0, 0, 0, 0, 0));
        vq.push_back(mk(1, B, 8'h13, 8'd0,   1, B, 0, 0, 0, 0, 0));
        vq.push_back(mk(1, B, 8'h14, 8'd0,   1, B, 0, 0, 0, 0, 0));
        vq.push_back(mk(1, B, 8'h15, 8'd0,   1, B, 0, 0, 0, 0, 0));
        vq.push_back(mk(1, T, 8'h16, 8'd0,   1, T, 1, 1, 1, 0, 0));
        vq.push_back(mk(0, T, 8'h00, 8'd0,   0, T, 0, 0, 1, 0, 0));
        // 3-word runt
        vq.push_back(mk(1, H, 8'h21, 8'd0,   1, H, 0, 0, 1, 0, 0));
        vq.push_back(mk(1, B, 8'h22, 8'd0,   1, B, 0, 0, 1, 0, 0));
        vq.push_back(mk(1, T, 8'h23, 8'd0,   1, T, 1, 0, 1, 1, 0));
        // orphan body+tail, then lone tail
        vq.push_back(mk(1, B, 8'h31, 8'd0,   0, B, 0, 0, 1, 1, 1));
        vq.push_back(mk(1, T, 8'h32, 8'd0,   0, T, 0, 0, 1, 1, 1));
        vq.push_back(mk(1, T, 8'h33, 8'd0,   0, T, 0, 0, 1, 1, 2));
        // head over threshold dropped whole (a head inside DROP is ignored)
        vq.push_back(mk(1, H, 8'h41, 8'd161, 0, H, 0, 0, 1, 1, 3));
        vq.push_back(mk(1, B, 8'h42, 8'd161, 0, B, 0, 0, 1, 1, 3));
        vq.push_back(mk(1, H, 8'h43, 8'd0,   0, H, 0, 0, 1, 1, 3));
        vq.push_back(mk(1, T, 8'h44, 8'd0,   0, T, 0, 0, 1, 1, 3));
        // head exactly at threshold accepted, 4 words = minimum legal length
        vq.push_back(mk(1, H, 8'h45, 8'd160, 1, H, 0, 0, 1, 1, 3));
        vq.push_back(mk(1, B, 8'h46, 8'd160, 1, B, 0, 0, 1, 1, 3));
        vq.push_back(mk(1, B, 8'h47, 8'd160, 1, B, 0, 0, 1, 1, 3));
        vq.push_back(mk(1, T, 8'h48, 8'd160, 1, T, 1, 1, 2, 1, 3));
        // truncation by a head at word 5, remainder of the new 8-word packet dropped
        vq.push_back(mk(1, H, 8'h51, 8'd0,   1, H, 0, 0, 2, 1, 3));
        vq.push_back(mk(1, B, 8'h52, 8'd0,   1, B, 0, 0, 2, 1, 3));
        vq.push_back(mk(1, B, 8'h53, 8'd0,   1, B, 0, 0, 2, 1, 3));
        vq.push_back(mk(1, B, 8'h54, 8'd0,   1, B, 0, 0, 2, 1, 3));
        vq.push_back(mk(1, H, 8'h55, 8'd0,   1, T, 1, 0, 2, 2, 4));
        for (int i = 0; i < 6; i++)
            vq.push_back(mk(1, B, 8'(8'h56 + i), 8'd0, 0, B, 0, 0, 2, 2, 4));
        vq.push_back(mk(1, T, 8'h5c, 8'd0,   0, T, 0, 0, 2, 2, 4));
        vq.push_back(mk(1, H, 8'h63, 8'd0,   1, H, 0, 0, 2, 2, 4));
        vq.push_back(mk(1, B, 8'h64, 8'd0,   1, B, 0, 0, 2, 2, 4));
        vq.push_back(mk(1, B, 8'h65, 8'd0,   1, B, 0, 0, 2, 2, 4));
        vq.push_back(mk(1, T, 8'h66, 8'd0,   1, T, 1, 1, 3, 2, 4));
        // illegal type mid-packet and in IDLE
        vq.push_back(mk(1, H, 8'h71, 8'd0,   1, H, 0, 0, 3, 2, 4));
        vq.push_back(mk(1, B, 8'h72, 8'd0,   1, B, 0, 0, 3, 2, 4));
        vq.push_back(mk(1, X, 8'h73, 8'd0,   1, T, 1, 0, 3, 3, 5));
        vq.push_back(mk(1, T, 8'h74, 8'd0,   0, T, 0, 0, 3, 3, 5));
        vq.push_back(mk(1, X, 8'h75, 8'd0,   0, X, 0, 0, 3, 3, 6));
        vq.push_back(mk(1, H, 8'h76, 8'd0,   1, H, 0, 0, 3, 3, 6));
        vq.push_back(mk(1, T, 8'h77, 8'd0,   1, T, 1, 0, 3, 4, 6));

        // reset values
        reset         = 1'b1;
        in_pkt_wrreq  = 1'b0;
        in_pkt        = '0;
        out_pkt_usedw = 8'd77;
        repeat (2) @(posedge clk);
        #1;
        chk("rst out_pkt_wrreq", 139'(out_pkt_wrreq), 139'(0));
        chk("rst out_valid_wrreq", 139'(out_valid_wrreq), 139'(0));
        chk("rst out_valid", 139'(out_valid), 139'(0));
        chk("rst out_pkt", out_pkt, 139'(0));
        chk("rst cnt_good", 139'(cnt_good), 139'(0));
        chk("rst cnt_bad", 139'(cnt_bad), 139'(0));
        chk("rst cnt_drop", 139'(cnt_drop), 139'(0));
        chk("in_pkt_usedw", 139'(in_pkt_usedw), 139'(8'd77));
        out_pkt_usedw = 8'd0;
        reset = 1'b0;

        foreach (vq[i]) apply(vq[i]);

        // 120-word packet: word 96 closed as a tail, 97..120 dropped
        for (int i = 1; i <= 120; i++) begin
            logic [2:0] typ;
            typ = (i == 1) ? H : ((i == 120) ? T : B);
            if (i < 96)       apply(mk(1, typ, 8'(i), 8'd0, 1, typ, 0, 0, 3, 4, 6));
            else if (i == 96) apply(mk(1, typ, 8'(i), 8'd0, 1, T,   1, 0, 3, 5, 6));
            else              apply(mk(1, typ, 8'(i), 8'd0, 0, typ, 0, 0, 3, 5, 6));
        end

        // reset at word 3 of a packet
        apply(mk(1, H, 8'h81, 8'd0, 1, H, 0, 0, 3, 5, 6));
        apply(mk(1, B, 8'h82, 8'd0, 1, B, 0, 0, 3, 5, 6));
        reset        = 1'b1;
        in_pkt_wrreq = 1'b1;
        in_pkt       = word(B, 8'h83);
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("midrst out_pkt_wrreq", 139'(out_pkt_wrreq), 139'(0));
        chk("midrst out_valid_wrreq", 139'(out_valid_wrreq), 139'(0));
        chk("midrst out_pkt", out_pkt, 139'(0));
        chk("midrst cnt_good", 139'(cnt_good), 139'(0));
        chk("midrst cnt_bad", 139'(cnt_bad), 139'(0));
        chk("midrst cnt_drop", 139'(cnt_drop), 139'(0));
        apply(mk(1, H, 8'h91, 8'd0, 1, H, 0, 0, 0, 0, 0));
        for (int i = 0; i < 4; i++)
            apply(mk(1, B, 8'(8'h92 + i), 8'd0, 1, B, 0, 0, 0, 0, 0));
        apply(mk(1, T, 8'h96, 8'd0, 1, T, 1, 1, 1, 0, 0));
        apply(mk(0, T, 8'h00, 8'd0, 0, T, 0, 0, 1, 0, 0));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
